// File: rtl/ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_event_decoder
//
// Turns a stream of PS/2 set-2 scan-code bytes into key events. The E0
// (extended) and F0 (break) prefixes are tracked by a four-state FSM. A
// completing byte produces an event {code, extended, break}, which is
// written into a small event FIFO on the same clock edge.
//
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat.
// With it defined, a held-key register {valid, ext, code} is kept. A make
// event that matches the held key is dropped. A make event for a different
// key is loaded into the register. A break event for the held key clears the
// register. Without the macro, every event is pushed and the register does
// not exist.
//
// Parameters
//   FIFO_DEPTH    event FIFO entries; must be a power of two from 2 to 16
//
// Ports
//   CLK           system clock; all state updates on its rising edge
//   RST           asynchronous active-high reset
//   SCAN_CODE     scan-code byte, sampled only while SCAN_VALID=1
//   SCAN_VALID    one-cycle strobe qualifying SCAN_CODE
//   EVT_READY     consumer accepts the head event
//   EVT_VALID     FIFO non-empty
//   EVT_CODE      key code of the head event (0 while empty)
//   EVT_EXTENDED  head event carried the E0 prefix
//   EVT_BREAK     head event is a release (F0 prefix)
//   FIFO_FULL     FIFO holds FIFO_DEPTH entries
//   OVERFLOW      sticky; an event was dropped because the FIFO was full
//   CODE_ERR      one-cycle pulse after a 0x00 or 0xFF byte
//   dbg_state     current prefix-FSM state, for observation only
//
// Handshake: the head event transfers at a rising edge where EVT_VALID=1 and
// EVT_READY=1. While EVT_VALID=1 and EVT_READY=0, EVT_CODE, EVT_EXTENDED and
// EVT_BREAK hold stable. EVT_VALID never drops without a transfer, except on
// reset.
// ---------------------------------------------------------------------------
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SCAN_CODE,
  input  logic       SCAN_VALID,
  input  logic       EVT_READY,
  output logic       EVT_VALID,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXTENDED,
  output logic       EVT_BREAK,
  output logic       FIFO_FULL,
  output logic       OVERFLOW,
  output logic       CODE_ERR,
  output logic [1:0] dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  generate
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two from 2 to 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic push_req;   // a completing byte arrived this cycle
  logic push_en;    // the event survives the optional filter
  logic evt_ext;
  logic evt_brk;
  logic code_bad;

  // Prefix FSM: next state and event classification
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    code_bad = 1'b0;
    evt_ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    evt_brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
    if (SCAN_VALID) begin
      if (SCAN_CODE == 8'hE0) begin
        // From any state. A pending break is discarded when E0 follows F0.
        state_d = GOT_E0;
      end else if (SCAN_CODE == 8'hF0) begin
        case (state_q)
          IDLE:    state_d = GOT_F0;
          GOT_E0:  state_d = GOT_E0F0;
          default: state_d = state_q;
        endcase
      end else if (SCAN_CODE == 8'h00 || SCAN_CODE == 8'hFF) begin
        code_bad = 1'b1;
        state_d  = IDLE;
      end else begin
        push_req = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_q;
  logic       held_ext_q;
  logic [7:0] held_code_q;
  logic       held_match;

  assign held_match = held_valid_q && (held_ext_q == evt_ext) &&
                      (held_code_q == SCAN_CODE);
  // A repeated make of the held key is auto-repeat; every break is kept
  assign push_en = push_req && !(!evt_brk && held_match);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
    end else if (push_req) begin
      if (!evt_brk && !held_match) begin
        held_valid_q <= 1'b1;
        held_ext_q   <= evt_ext;
        held_code_q  <= SCAN_CODE;
      end else if (evt_brk && held_match) begin
        held_valid_q <= 1'b0;
      end
    end
  end
`else
  assign push_en = push_req;
`endif

  // Event FIFO. The pointers carry one extra wrap bit so full and empty are
  // distinguishable without a counter.
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]  head;
  logic        do_pop;
  logic        do_push;
  logic        overflow_q;
  logic        code_err_q;

  assign EVT_VALID = (wr_ptr_q != rd_ptr_q);
  assign FIFO_FULL = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = EVT_VALID && EVT_READY;
  // When the FIFO is full, a simultaneous pop frees the slot being written.
  // The head is read before the edge, so the overwrite is safe.
  assign do_push   = push_en && (!FIFO_FULL || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= {SCAN_CODE, evt_ext, evt_brk};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push_en && FIFO_FULL && !do_pop) begin
        overflow_q <= 1'b1;
      end
      code_err_q <= code_bad;
    end
  end

  // Head fields are forced to zero while empty so reset state is defined
  // without resetting the storage array.
  assign head         = mem[rd_ptr_q[AW-1:0]];
  assign EVT_CODE     = EVT_VALID ? head[9:2] : 8'h00;
  assign EVT_EXTENDED = EVT_VALID ? head[1]   : 1'b0;
  assign EVT_BREAK    = EVT_VALID ? head[0]   : 1'b0;
  assign OVERFLOW     = overflow_q;
  assign CODE_ERR     = code_err_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_decoder
//
// Self-checking bench for ps2_key_event_decoder with FIFO_DEPTH=4. Expected
// events {code, ext, brk} are queued when bytes are driven. A negedge monitor
// pops the queue and compares it with the head whenever a transfer is about
// to happen.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SCAN_CODE = 8'h00;
  logic       SCAN_VALID = 1'b0;
  logic       EVT_READY = 1'b0;
  logic       EVT_VALID;
  logic [7:0] EVT_CODE;
  logic       EVT_EXTENDED;
  logic       EVT_BREAK;
  logic       FIFO_FULL;
  logic       OVERFLOW;
  logic       CODE_ERR;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_decoder #(.FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .SCAN_CODE(SCAN_CODE), .SCAN_VALID(SCAN_VALID),
    .EVT_READY(EVT_READY), .EVT_VALID(EVT_VALID), .EVT_CODE(EVT_CODE),
    .EVT_EXTENDED(EVT_EXTENDED), .EVT_BREAK(EVT_BREAK),
    .FIFO_FULL(FIFO_FULL), .OVERFLOW(OVERFLOW), .CODE_ERR(CODE_ERR),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the next posedge when VALID & READY
  always @(negedge CLK) begin
    if (!RST && EVT_VALID && EVT_READY) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_evt", 32'(exp_q.size()), 1);
      end else begin
        check_eq("evt", {EVT_CODE, EVT_EXTENDED, EVT_BREAK}, exp_q.pop_front());
      end
    end
  end

  // driver tasks; all are entered just after a posedge
  task automatic send_byte(input logic [7:0] b);
    SCAN_CODE  = b;
    SCAN_VALID = 1'b1;
    @(posedge CLK); #1;
    SCAN_VALID = 1'b0;
  endtask

  task automatic exp_evt(input logic [7:0] c, input logic e, input logic k);
    exp_q.push_back({c, e, k});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    SCAN_CODE  = 8'hE0;   // must be ignored while in reset
    SCAN_VALID = 1'b1;
    #1;
    check_eq("rst_valid", EVT_VALID, 0);
    check_eq("rst_head", {EVT_CODE, EVT_EXTENDED, EVT_BREAK}, 0);
    check_eq("rst_flags", {FIFO_FULL, OVERFLOW, CODE_ERR}, 0);
    check_eq("rst_state", dbg_state, 0);
    @(posedge CLK); #1;
    RST        = 1'b0;
    SCAN_VALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    EVT_READY = 1'b1;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge CLK); #1;
      budget++;
    end
    idle(2);
    check_eq({"drain_", tag}, 32'(exp_q.size()), 0);
    check_eq({"empty_", tag}, EVT_VALID, 0);
  endtask

  initial begin
    logic [7:0] rc;
    logic       re;
    #2;
    do_reset();

    // Make then break, READY high; VALID rises one edge after the last byte
    EVT_READY = 1'b1;
    check_eq("pre_valid", EVT_VALID, 0);
    exp_evt(8'h1C, 0, 0); send_byte(8'h1C);
    check_eq("lat_make", EVT_VALID, 1);
    exp_evt(8'h1C, 0, 1); send_byte(8'hF0);
    send_byte(8'h1C);
    check_eq("lat_break", EVT_VALID, 1);
    drain("basic");

    // Extended make and break
    exp_evt(8'h75, 1, 0); send_byte(8'hE0); send_byte(8'h75);
    exp_evt(8'h75, 1, 1); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain("ext");

    // Prefix corner transitions
    exp_evt(8'h6B, 1, 0); send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
    exp_evt(8'h1B, 0, 1); send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1B);
    exp_evt(8'h74, 1, 0); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0);
    send_byte(8'h74);
    exp_evt(8'h72, 1, 0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h72);
    exp_evt(8'h5A, 1, 1); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0);
    send_byte(8'h5A);
    drain("corners");

    // Overflow: five makes, nobody reading; the fifth is lost
    EVT_READY = 1'b0;
    exp_evt(8'h15, 0, 0); send_byte(8'h15);
    exp_evt(8'h1D, 0, 0); send_byte(8'h1D);
    exp_evt(8'h24, 0, 0); send_byte(8'h24);
    check_eq("not_full_3", FIFO_FULL, 0);
    exp_evt(8'h2D, 0, 0); send_byte(8'h2D);
    check_eq("full_4", FIFO_FULL, 1);
    check_eq("no_ovf_4", OVERFLOW, 0);
    send_byte(8'h2C);
    check_eq("full_5", FIFO_FULL, 1);
    check_eq("ovf_5", OVERFLOW, 1);
    check_eq("head_stable", {EVT_CODE, EVT_EXTENDED, EVT_BREAK}, {8'h15, 2'b00});
    drain("ovf");
    check_eq("ovf_sticky", OVERFLOW, 1);
    do_reset();
    check_eq("ovf_cleared", OVERFLOW, 0);

    // Full FIFO with push and pop on the same edge
    EVT_READY = 1'b0;
    exp_evt(8'h16, 0, 0); send_byte(8'h16);
    exp_evt(8'h1E, 0, 0); send_byte(8'h1E);
    exp_evt(8'h26, 0, 0); send_byte(8'h26);
    exp_evt(8'h25, 0, 0); send_byte(8'h25);
    exp_evt(8'h2E, 0, 0);
    EVT_READY = 1'b1;
    send_byte(8'h2E);
    EVT_READY = 1'b0;
    check_eq("pp_full", FIFO_FULL, 1);
    check_eq("pp_no_ovf", OVERFLOW, 0);
    check_eq("pp_head", {EVT_CODE, EVT_EXTENDED, EVT_BREAK}, {8'h1E, 2'b00});
    drain("pushpop");

    // Reset discards a partial prefix; bad codes pulse CODE_ERR
    send_byte(8'hE0);
    do_reset();
    EVT_READY = 1'b1;
    exp_evt(8'h74, 0, 0); send_byte(8'h74);
    drain("rst_prefix");
    check_eq("err_idle", CODE_ERR, 0);
    send_byte(8'hFF);
    check_eq("err_ff_pulse", CODE_ERR, 1);
    check_eq("err_ff_noevt", EVT_VALID, 0);
    idle(1);
    check_eq("err_ff_end", CODE_ERR, 0);
    send_byte(8'hE0); send_byte(8'h00);
    check_eq("err_00_pulse", CODE_ERR, 1);
    exp_evt(8'h29, 0, 0); send_byte(8'h29);   // the 00 also dropped the E0
    check_eq("err_00_end", CODE_ERR, 0);
    drain("err");

    // Typematic repeat sequence
    exp_evt(8'h1C, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_evt(8'h1C, 0, 1);
    exp_evt(8'h1C, 0, 0);
`else
    exp_evt(8'h1C, 0, 0);
    exp_evt(8'h1C, 0, 0);
    exp_evt(8'h1C, 0, 1);
    exp_evt(8'h1C, 0, 0);
`endif
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    drain("typematic");
    do_reset();

    // Random make/break pairs, random extended prefix
    EVT_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rc = 8'($urandom_range(8'h01, 8'h7F));
      re = 1'($urandom_range(0, 1));
      exp_evt(rc, re, 0);
      exp_evt(rc, re, 1);
      if (re) send_byte(8'hE0);
      send_byte(rc);
      if (re) send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(rc);
      idle(int'($urandom_range(0, 2)));
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_decoder.md
PS2_KEY_EVENT_DECODER -- requirements
Module: ps2_key_event_decoder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter FIFO_DEPTH, default 4, event FIFO entries; the block SHALL support only powers of two from 2 to 16.
REQ-003 Port CLK, input, 1, system clock; all state SHALL update on its rising edge.
REQ-004 Port RST, input, 1, asynchronous active-high reset.
REQ-005 Port SCAN_CODE, input, 8, debounced scan-code byte from the upstream debounce/shift-register stage; the block SHALL sample it only when SCAN_VALID=1.
REQ-006 Port SCAN_VALID, input, 1, one-cycle strobe; SCAN_CODE is valid while it is high.
REQ-007 Port EVT_READY, input, 1, consumer accepts the head event.
REQ-008 Port EVT_VALID, output, 1, the FIFO is non-empty.
REQ-009 Port EVT_CODE, output, 8, key code of the head event.
REQ-010 Port EVT_EXTENDED, output, 1, the head event had the E0 prefix.
REQ-011 Port EVT_BREAK, output, 1, the head event is a release (F0 prefix).
REQ-012 Port FIFO_FULL, output, 1, the FIFO holds FIFO_DEPTH entries.
REQ-013 Port OVERFLOW, output, 1, sticky: an event was dropped.
REQ-014 Port CODE_ERR, output, 1, one-cycle pulse on receipt of 0x00 or 0xFF.

Function
REQ-015 The FSM SHALL have four states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
REQ-016 Transitions on SCAN_VALID SHALL be:
- IDLE + E0 -> GOT_E0
- IDLE + F0 -> GOT_F0
- GOT_E0 + F0 -> GOT_E0F0
- GOT_E0 + E0 -> GOT_E0
- GOT_F0 or GOT_E0F0 + E0 -> GOT_E0, discarding the pending break
- GOT_F0 or GOT_E0F0 + F0 -> unchanged
REQ-017 In any state, a byte other than E0, F0, 00 or FF SHALL push event {code, ext, brk} and return to IDLE. ext=1 in GOT_E0 and GOT_E0F0; brk=1 in GOT_F0 and GOT_E0F0.
REQ-018 0x00 or 0xFF SHALL pulse CODE_ERR for one cycle, push nothing, and return the FSM to IDLE.
REQ-019 Latency: a completing byte strobed at edge N SHALL be written at edge N. EVT_VALID and the head outputs SHALL reflect it after edge N when the FIFO was empty.
REQ-020 A pop SHALL occur at an edge where EVT_VALID=1 and EVT_READY=1. EVT_* SHALL hold stable while EVT_VALID=1 and EVT_READY=0.
REQ-021 Push and pop at the same edge SHALL both be performed, including when the FIFO is full; the count is unchanged.
REQ-022 Push while full with no pop SHALL drop the event, set OVERFLOW, and leave FIFO contents unchanged.
REQ-023 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and the rest are equal.

Reset
REQ-024 On RST=1 the block SHALL immediately set FSM=IDLE, empty the FIFO, and drive EVT_VALID=0, EVT_CODE=0, EVT_EXTENDED=0, EVT_BREAK=0, FIFO_FULL=0, OVERFLOW=0, CODE_ERR=0.
REQ-025 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix. SCAN_VALID during reset SHALL be ignored.
REQ-026 OVERFLOW SHALL clear only on reset.

Configuration
REQ-027 With macro PS2_TYPEMATIC_FILTER_EN defined, the block SHALL:
- hold a held-key register {valid, ext, code}
- drop a make event equal to the held key (auto-repeat)
- load a make event that differs into the register
- clear the register on a break event for the held key
REQ-028 Without PS2_TYPEMATIC_FILTER_EN, every make event SHALL be pushed and no held-key register SHALL exist.

Verification
REQ-029 Bytes 1C, then F0 1C, EVT_READY=1 -> events {1C,0,0} then {1C,0,1}; EVT_VALID rises one edge after each final byte.
REQ-030 Bytes E0 75, then E0 F0 75 -> events {75,1,0} then {75,1,1}.
REQ-031 EVT_READY=0, FIFO_DEPTH=4, five make codes 15 1D 24 2D 2C -> FIFO_FULL=1, OVERFLOW=1, the four oldest events are retained, and 2C is lost.
REQ-032 FIFO full, push and pop at the same edge -> count stays 4, FIFO_FULL stays 1, OVERFLOW stays 0.
REQ-033 E0 then RST pulse then 74 -> event {74,0,0}; byte FF -> one-cycle CODE_ERR pulse and no event.
REQ-034 PS2_TYPEMATIC_FILTER_EN defined, bytes 1C 1C 1C F0 1C 1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}; with the macro undefined -> 5 events.
